// File: rtl/stream_pkg.sv
// Types shared by the stream controller and the CSR glue: controller FSM states and the
// packed {fir, dft} mode pair.
package stream_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic fir;
        logic dft;
    } dsp_mode_t;

    function automatic logic mode_is_dsp(input dsp_mode_t m);
        return m.fir | m.dft;
    endfunction

endpackage

// File: rtl/stream_pkt_tracker.sv
// Tracks whether an Avalon-ST interface is inside a packet and flags accepted end-of-packet beats.
// Observes a valid/ready pair only; adds no latency and never applies backpressure.
module stream_pkt_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic ready,
    input  logic sop,
    input  logic eop,
    output logic in_pkt,
    output logic eop_fire
);

    logic fire;
    logic in_pkt_q;
    logic in_pkt_d;

    assign fire     = valid & ready;
    assign eop_fire = fire & eop;
    assign in_pkt   = in_pkt_q;

    // A single-beat packet (sop & eop) takes the eop branch and never opens a packet.
    always_comb begin
        in_pkt_d = in_pkt_q;
        if (fire && eop) begin
            in_pkt_d = 1'b0;
        end else if (fire && sop) begin
            in_pkt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_pkt_q <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
        end
    end

endmodule

// File: rtl/dsp_stream_ctrl.sv
// Routes Avalon-ST traffic through the DSP or around it with zero added latency; mode changes
// wait for a packet boundary and a fully drained DSP, gating new packets at ingress meanwhile.
module dsp_stream_ctrl
    import stream_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_fir_en,
    input  logic        req_dft_en,
    output logic        fir_en,
    output logic        dft_en,
    output logic        active_dsp,
    output logic        switch_pending,
    output logic        sink_ready,
    input  logic [31:0] sink_data,
    input  logic        sink_valid,
    input  logic        sink_sop,
    input  logic        sink_eop,
    output logic [31:0] source_data,
    output logic        source_valid,
    output logic        source_sop,
    output logic        source_eop,
    input  logic        source_ready,
    input  logic        dsp_sink_ready,
    output logic [31:0] dsp_sink_data,
    output logic        dsp_sink_valid,
    output logic        dsp_sink_sop,
    output logic        dsp_sink_eop,
    input  logic [31:0] dsp_source_data,
    input  logic        dsp_source_valid,
    input  logic        dsp_source_sop,
    input  logic        dsp_source_eop,
    output logic        dsp_source_ready
);

    localparam logic [CNT_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    ctrl_state_t      state_q, state_d;
    dsp_mode_t        mode_q, mode_d;
    dsp_mode_t        req_mode;
    logic [CNT_W-1:0] pending_q, pending_d;

    logic path_dsp;
    logic gate;
    logic fwd_valid;
    logic in_pkt;
    logic out_pkt;
    logic in_eop_fire;
    logic dsp_eop_fire;
    logic pend_inc;
    logic pend_dec;
    logic out_eop_fire_unused;
    logic dsp_out_pkt_unused;

    assign req_mode = {req_fir_en, req_dft_en};
    assign path_dsp = mode_is_dsp(mode_q);

    // The gate only ever acts between packets, so a beat already presented mid-packet keeps its valid.
    assign gate = ((state_q != RUN) && !in_pkt)
               || ((pending_q == PEND_MAX) && !in_pkt && path_dsp);
    assign fwd_valid = sink_valid & ~gate;

    always_comb begin
        sink_ready       = source_ready & ~gate;
        source_valid     = fwd_valid;
        source_data      = sink_data;
        source_sop       = sink_sop;
        source_eop       = sink_eop;
        dsp_sink_valid   = 1'b0;
        dsp_source_ready = 1'b0;
        if (path_dsp) begin
            sink_ready       = dsp_sink_ready & ~gate;
            dsp_sink_valid   = fwd_valid;
            source_valid     = dsp_source_valid;
            source_data      = dsp_source_data;
            source_sop       = dsp_source_sop;
            source_eop       = dsp_source_eop;
            dsp_source_ready = source_ready;
        end
    end

    assign dsp_sink_data = sink_data;
    assign dsp_sink_sop  = sink_sop;
    assign dsp_sink_eop  = sink_eop;

    stream_pkt_tracker u_in_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (sink_valid),
        .ready    (sink_ready),
        .sop      (sink_sop),
        .eop      (sink_eop),
        .in_pkt   (in_pkt),
        .eop_fire (in_eop_fire)
    );

    stream_pkt_tracker u_out_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (source_valid),
        .ready    (source_ready),
        .sop      (source_sop),
        .eop      (source_eop),
        .in_pkt   (out_pkt),
        .eop_fire (out_eop_fire_unused)
    );

    stream_pkt_tracker u_dsp_trk (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (dsp_source_valid),
        .ready    (dsp_source_ready),
        .sop      (dsp_source_sop),
        .eop      (dsp_source_eop),
        .in_pkt   (dsp_out_pkt_unused),
        .eop_fire (dsp_eop_fire)
    );

    assign pend_inc = in_eop_fire & path_dsp;
    assign pend_dec = dsp_eop_fire;

    always_comb begin
        pending_d = pending_q;
        if (pend_inc && !pend_dec) begin
            pending_d = pending_q + PEND_ONE;
        end else if (pend_dec && !pend_inc) begin
            pending_d = pending_q - PEND_ONE;
        end
    end

    // Even FIR <-> DFT changes drain fully: the DSP core must never see a torn packet.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            RUN: begin
                if (req_mode != mode_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (req_mode == mode_q) begin
                    state_d = RUN;
                end else if (!in_pkt && !out_pkt && (pending_q == '0)) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                mode_d  = req_mode;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            mode_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
        end
    end

    assign fir_en         = mode_q.fir;
    assign dft_en         = mode_q.dft;
    assign active_dsp     = path_dsp;
    assign switch_pending = (state_q != RUN);

endmodule

// File: tb/tb_dsp_stream_ctrl.sv
// Directed bench for dsp_stream_ctrl (CNT_W = 2): per-cycle vector table with hand-computed
// expectations covering bypass, switching, drain, revert, saturation and reset mid-packet.
module tb_dsp_stream_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_fir_en, req_dft_en;
    logic        fir_en, dft_en, active_dsp, switch_pending;
    logic        sink_ready;
    logic [31:0] sink_data;
    logic        sink_valid, sink_sop, sink_eop;
    logic [31:0] source_data;
    logic        source_valid, source_sop, source_eop;
    logic        source_ready;
    logic        dsp_sink_ready;
    logic [31:0] dsp_sink_data;
    logic        dsp_sink_valid, dsp_sink_sop, dsp_sink_eop;
    logic [31:0] dsp_source_data;
    logic        dsp_source_valid, dsp_source_sop, dsp_source_eop;
    logic        dsp_source_ready;

    int checks = 0;
    int errors = 0;

    dsp_stream_ctrl #(.CNT_W(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_fir_en       (req_fir_en),
        .req_dft_en       (req_dft_en),
        .fir_en           (fir_en),
        .dft_en           (dft_en),
        .active_dsp       (active_dsp),
        .switch_pending   (switch_pending),
        .sink_ready       (sink_ready),
        .sink_data        (sink_data),
        .sink_valid       (sink_valid),
        .sink_sop         (sink_sop),
        .sink_eop         (sink_eop),
        .source_data      (source_data),
        .source_valid     (source_valid),
        .source_sop       (source_sop),
        .source_eop       (source_eop),
        .source_ready     (source_ready),
        .dsp_sink_ready   (dsp_sink_ready),
        .dsp_sink_data    (dsp_sink_data),
        .dsp_sink_valid   (dsp_sink_valid),
        .dsp_sink_sop     (dsp_sink_sop),
        .dsp_sink_eop     (dsp_sink_eop),
        .dsp_source_data  (dsp_source_data),
        .dsp_source_valid (dsp_source_valid),
        .dsp_source_sop   (dsp_source_sop),
        .dsp_source_eop   (dsp_source_eop),
        .dsp_source_ready (dsp_source_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag pairs are {sop, eop}; mode pairs are {fir, dft}.
    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        sv;
        logic [1:0]  sf;
        logic [31:0] sd;
        logic        src_rdy;
        logic        dsk_rdy;
        logic        dv;
        logic [1:0]  df;
        logic [31:0] dd;
        logic        e_srdy;
        logic        e_sv;
        logic [1:0]  e_sf;
        logic [31:0] e_sd;
        logic        e_dsv;
        logic        e_dsrdy;
        logic [1:0]  e_mode;
        logic        e_swp;
    } vec_t;

    localparam int NV = 46;
    vec_t vecs[NV];

    function automatic vec_t mk(input int rst, input int req, input int sv, input int sf,
                                input int sd, input int src_rdy, input int dsk_rdy, input int dv,
                                input int df, input int dd, input int e_srdy, input int e_sv,
                                input int e_sf, input int e_sd, input int e_dsv, input int e_dsrdy,
                                input int e_mode, input int e_swp);
        vec_t v;
        v.rst = rst[0];         v.req = req[1:0];      v.sv = sv[0];          v.sf = sf[1:0];
        v.sd = sd;              v.src_rdy = src_rdy[0]; v.dsk_rdy = dsk_rdy[0]; v.dv = dv[0];
        v.df = df[1:0];         v.dd = dd;             v.e_srdy = e_srdy[0];  v.e_sv = e_sv[0];
        v.e_sf = e_sf[1:0];     v.e_sd = e_sd;         v.e_dsv = e_dsv[0];    v.e_dsrdy = e_dsrdy[0];
        v.e_mode = e_mode[1:0]; v.e_swp = e_swp[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    initial begin
        //            rst req sv sf sd     srd dkr dv df dd      | srdy sv sf sd     dsv dsr mode swp
        // bypass 4-beat packet
        vecs[0]  = mk(1, 0, 1, 2, 'h01,  1, 1, 0, 0, 0,      1, 1, 2, 'h01,  0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 1, 0, 'h02,  1, 1, 0, 0, 0,      1, 1, 0, 'h02,  0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 0, 'h03,  1, 1, 0, 0, 0,      1, 1, 0, 'h03,  0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 1, 1, 'h04,  1, 1, 0, 0, 0,      1, 1, 1, 'h04,  0, 0, 0, 0);
        // FIR requested at beat 3 of an 8-beat packet
        vecs[4]  = mk(1, 0, 1, 2, 'h11,  1, 1, 0, 0, 0,      1, 1, 2, 'h11,  0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 1, 0, 'h12,  1, 1, 0, 0, 0,      1, 1, 0, 'h12,  0, 0, 0, 0);
        vecs[6]  = mk(1, 2, 1, 0, 'h13,  1, 1, 0, 0, 0,      1, 1, 0, 'h13,  0, 0, 0, 0);
        vecs[7]  = mk(1, 2, 1, 0, 'h14,  1, 1, 0, 0, 0,      1, 1, 0, 'h14,  0, 0, 0, 1);
        vecs[8]  = mk(1, 2, 1, 0, 'h15,  1, 1, 0, 0, 0,      1, 1, 0, 'h15,  0, 0, 0, 1);
        vecs[9]  = mk(1, 2, 1, 0, 'h16,  1, 1, 0, 0, 0,      1, 1, 0, 'h16,  0, 0, 0, 1);
        vecs[10] = mk(1, 2, 1, 0, 'h17,  1, 1, 0, 0, 0,      1, 1, 0, 'h17,  0, 0, 0, 1);
        vecs[11] = mk(1, 2, 1, 1, 'h18,  1, 1, 0, 0, 0,      1, 1, 1, 'h18,  0, 0, 0, 1);
        vecs[12] = mk(1, 2, 1, 2, 'h21,  1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 1);
        vecs[13] = mk(1, 2, 1, 2, 'h21,  1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 1);
        vecs[14] = mk(1, 2, 1, 2, 'h21,  1, 1, 0, 0, 0,      1, 0, 0, 0,     1, 1, 2, 0);
        vecs[15] = mk(1, 2, 1, 1, 'h22,  1, 1, 0, 0, 0,      1, 0, 0, 0,     1, 1, 2, 0);
        vecs[16] = mk(1, 2, 1, 3, 'h31,  1, 1, 0, 0, 0,      1, 0, 0, 0,     1, 1, 2, 0);
        // disable with two packets inside the DSP
        vecs[17] = mk(1, 0, 0, 0, 0,     1, 1, 0, 0, 0,      1, 0, 0, 0,     0, 1, 2, 0);
        vecs[18] = mk(1, 0, 1, 3, 'h41,  1, 1, 1, 2, 'hA1,   0, 1, 2, 'hA1,  0, 1, 2, 1);
        vecs[19] = mk(1, 0, 1, 3, 'h41,  1, 1, 1, 1, 'hA2,   0, 1, 1, 'hA2,  0, 1, 2, 1);
        vecs[20] = mk(1, 0, 1, 3, 'h41,  1, 1, 1, 3, 'hB1,   0, 1, 3, 'hB1,  0, 1, 2, 1);
        vecs[21] = mk(1, 0, 1, 3, 'h41,  1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 1, 2, 1);
        vecs[22] = mk(1, 0, 1, 3, 'h41,  1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 1, 2, 1);
        vecs[23] = mk(1, 0, 1, 3, 'h41,  1, 1, 0, 0, 0,      1, 1, 3, 'h41,  0, 0, 0, 0);
        // DFT request reverts after one cycle
        vecs[24] = mk(1, 1, 0, 0, 0,     1, 1, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0);
        vecs[25] = mk(1, 0, 0, 0, 0,     1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 1);
        vecs[26] = mk(1, 0, 0, 0, 0,     1, 1, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0);
        vecs[27] = mk(1, 0, 1, 3, 'h51,  1, 1, 0, 0, 0,      1, 1, 3, 'h51,  0, 0, 0, 0);
        // enable FIR from idle, then saturate pending (max 3)
        vecs[28] = mk(1, 2, 0, 0, 0,     1, 1, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0);
        vecs[29] = mk(1, 2, 0, 0, 0,     1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 1);
        vecs[30] = mk(1, 2, 0, 0, 0,     1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 1);
        vecs[31] = mk(1, 2, 1, 3, 'h61,  0, 1, 0, 0, 0,      1, 0, 0, 0,     1, 0, 2, 0);
        vecs[32] = mk(1, 2, 1, 3, 'h62,  0, 1, 0, 0, 0,      1, 0, 0, 0,     1, 0, 2, 0);
        vecs[33] = mk(1, 2, 1, 3, 'h63,  0, 1, 0, 0, 0,      1, 0, 0, 0,     1, 0, 2, 0);
        vecs[34] = mk(1, 2, 1, 3, 'h64,  0, 1, 1, 3, 'hC1,   0, 1, 3, 'hC1,  0, 0, 2, 0);
        vecs[35] = mk(1, 2, 1, 3, 'h64,  0, 1, 1, 3, 'hC1,   0, 1, 3, 'hC1,  0, 0, 2, 0);
        vecs[36] = mk(1, 2, 1, 3, 'h64,  1, 1, 1, 3, 'hC1,   0, 1, 3, 'hC1,  0, 1, 2, 0);
        vecs[37] = mk(1, 2, 1, 3, 'h64,  1, 1, 1, 3, 'hC2,   1, 1, 3, 'hC2,  1, 1, 2, 0);
        // reset during beat 2 of a DSP packet
        vecs[38] = mk(1, 2, 1, 2, 'h71,  1, 1, 0, 0, 0,      1, 0, 0, 0,     1, 1, 2, 0);
        vecs[39] = mk(0, 2, 1, 0, 'h72,  1, 1, 0, 0, 0,      1, 0, 0, 0,     1, 1, 2, 0);
        vecs[40] = mk(1, 0, 1, 0, 'h73,  1, 1, 0, 0, 0,      1, 1, 0, 'h73,  0, 0, 0, 0);
        // pending cleared by reset: FIR+DFT switch completes in minimum time
        vecs[41] = mk(1, 3, 0, 0, 0,     1, 1, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0);
        vecs[42] = mk(1, 3, 0, 0, 0,     1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 1);
        vecs[43] = mk(1, 3, 0, 0, 0,     1, 1, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 1);
        vecs[44] = mk(1, 3, 0, 0, 0,     1, 1, 0, 0, 0,      1, 0, 0, 0,     0, 1, 3, 0);
        vecs[45] = mk(1, 3, 1, 3, 'h81,  1, 0, 0, 0, 0,      0, 0, 0, 0,     1, 1, 3, 0);

        rst_n = 1'b0;
        req_fir_en = 1'b0;  req_dft_en = 1'b0;
        sink_valid = 1'b0;  sink_sop = 1'b0;  sink_eop = 1'b0;  sink_data = '0;
        source_ready = 1'b1;
        dsp_sink_ready = 1'b1;
        dsp_source_valid = 1'b0;  dsp_source_sop = 1'b0;  dsp_source_eop = 1'b0;
        dsp_source_data = '0;

        repeat (2) @(posedge clk);
        #1;
        sink_valid = 1'b1;
        sink_data = 32'hDEAD;
        source_ready = 1'b0;
        #2;
        chk("rst.fir_en", {31'd0, fir_en}, 32'd0);
        chk("rst.dft_en", {31'd0, dft_en}, 32'd0);
        chk("rst.active_dsp", {31'd0, active_dsp}, 32'd0);
        chk("rst.switch_pending", {31'd0, switch_pending}, 32'd0);
        chk("rst.sink_ready_lo", {31'd0, sink_ready}, 32'd0);
        chk("rst.dsp_sink_valid", {31'd0, dsp_sink_valid}, 32'd0);
        chk("rst.dsp_source_ready", {31'd0, dsp_source_ready}, 32'd0);
        chk("rst.source_valid", {31'd0, source_valid}, 32'd1);
        chk("rst.source_data", source_data, 32'hDEAD);
        source_ready = 1'b1;
        #1;
        chk("rst.sink_ready_hi", {31'd0, sink_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            rst_n            = vecs[i].rst;
            {req_fir_en, req_dft_en} = vecs[i].req;
            sink_valid       = vecs[i].sv;
            {sink_sop, sink_eop} = vecs[i].sf;
            sink_data        = vecs[i].sd;
            source_ready     = vecs[i].src_rdy;
            dsp_sink_ready   = vecs[i].dsk_rdy;
            dsp_source_valid = vecs[i].dv;
            {dsp_source_sop, dsp_source_eop} = vecs[i].df;
            dsp_source_data  = vecs[i].dd;
            #3;
            chk($sformatf("v%0d.sink_ready", i), {31'd0, sink_ready}, {31'd0, vecs[i].e_srdy});
            chk($sformatf("v%0d.source_valid", i), {31'd0, source_valid}, {31'd0, vecs[i].e_sv});
            if (vecs[i].e_sv) begin
                chk($sformatf("v%0d.source_data", i), source_data, vecs[i].e_sd);
                chk($sformatf("v%0d.source_sop_eop", i), {30'd0, source_sop, source_eop},
                    {30'd0, vecs[i].e_sf});
            end
            chk($sformatf("v%0d.dsp_sink_valid", i), {31'd0, dsp_sink_valid}, {31'd0, vecs[i].e_dsv});
            if (vecs[i].e_dsv) begin
                chk($sformatf("v%0d.dsp_sink_data", i), dsp_sink_data, vecs[i].sd);
                chk($sformatf("v%0d.dsp_sink_sop_eop", i), {30'd0, dsp_sink_sop, dsp_sink_eop},
                    {30'd0, vecs[i].sf});
            end
            chk($sformatf("v%0d.dsp_source_ready", i), {31'd0, dsp_source_ready},
                {31'd0, vecs[i].e_dsrdy});
            chk($sformatf("v%0d.mode", i), {30'd0, fir_en, dft_en}, {30'd0, vecs[i].e_mode});
            chk($sformatf("v%0d.active_dsp", i), {31'd0, active_dsp}, {31'd0, |vecs[i].e_mode});
            chk($sformatf("v%0d.switch_pending", i), {31'd0, switch_pending}, {31'd0, vecs[i].e_swp});
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_stream_ctrl.md
# dsp_stream_ctrl

Packet-aware stream controller that sits between the Avalon-ST sink/source ports and the DSP core. It routes traffic either through the DSP (FIR and/or DFT) or around it as a bypass. It takes the CSR mode bits and applies mode changes only at packet boundaries, after all in-flight packets have drained. This prevents mid-packet path switching and torn DSP packets.

## Interface
- `CNT_W`, default 4: width of the in-DSP packet counter; at most 2^CNT_W−1 packets may be pending inside the DSP.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_fir_en`, `req_dft_en`  in  1 each  requested mode, driven by the CSR `DSP_CR` fields
- `fir_en`, `dft_en`  out  1 each  applied mode, fed to the DSP `hwif_in`
- `active_dsp`  out  1  applied path is DSP (`fir_en | dft_en`)
- `switch_pending`  out  1  FSM is in DRAIN or SWITCH
- `sink_ready` out, `sink_data` in 32, `sink_valid`/`sink_sop`/`sink_eop` in 1: upstream Avalon-ST
- `source_data` out 32, `source_valid`/`source_sop`/`source_eop` out 1, `source_ready` in: downstream Avalon-ST
- `dsp_sink_*` and `dsp_source_*`: same fields as above, facing the DSP (`dsp_sink_ready` in, `dsp_source_ready` out)

## Operation
- **Applied mode** is the registered pair {`fir_en`, `dft_en`}. The path is DSP if either bit is set; otherwise bypass.
- **Bypass routing:**
  - `source_*` equals `sink_*`, and `sink_ready` equals `source_ready`, both combinational.
  - `dsp_sink_valid` = 0 and `dsp_source_ready` = 0.
- **DSP routing:**
  - `dsp_sink_*` equals `sink_*`, and `sink_ready` equals `dsp_sink_ready`.
  - `source_*` equals `dsp_source_*`, and `dsp_source_ready` equals `source_ready`.
- **Trackers:**
  - `in_pkt` is set on an accepted beat with `sop & !eop` and cleared on an accepted `eop`, on the upstream side.
  - `out_pkt` behaves the same way on the downstream side.
  - `pending` increments on an `eop` accepted into the DSP and decrements on an `eop` emitted by the DSP.
  - A simultaneous increment and decrement leaves `pending` unchanged.
- **Gate:** when asserted, it forces `sink_ready` = 0 and drops the forwarded `valid` on the ingress side. It is asserted when either condition holds:
  - (state != RUN and `in_pkt` = 0), or
  - (`pending` = max, `in_pkt` = 0, path = DSP).
- **FSM states:**
  - RUN: if the request differs from the applied mode, go to DRAIN.
  - DRAIN: new packets are gated. The current input packet completes, and the egress side continues to flow. If the request returns to equal the applied mode, go back to RUN with no switch. Otherwise, when `in_pkt` = 0, `out_pkt` = 0 and `pending` = 0, go to SWITCH.
  - SWITCH: lasts one cycle. Load `fir_en`/`dft_en` from the request as sampled this cycle, keep the gate asserted, then go to RUN.
- Changing only between FIR, DFT and FIR+DFT while already on the DSP path also drains fully before switching.

## Timing
- **Reset values:**
  - state RUN, `fir_en` = `dft_en` = 0, `active_dsp` = 0, `switch_pending` = 0.
  - `in_pkt` = `out_pkt` = 0, `pending` = 0.
  - Combinational outputs follow bypass routing: `sink_ready` = `source_ready`, `dsp_*` valid/ready = 0.
- **Reset mid-operation:** everything returns to the reset values in the next cycle. Partial packets are abandoned, with no flush.
- **Switch latency from idle:**
  - The request changes in cycle t.
  - DRAIN in t+1, SWITCH in t+2, RUN with the new mode in t+3.
  - The first beat is accepted on the new path at t+3.
- **Data path:** zero added latency and no data registers.
- **Single-beat packet** (`sop & eop` in the same beat): `in_pkt` stays 0. In DSP mode `pending` still increments.
- Avalon-ST rules hold: data and flags are stable while `valid & !ready`. The gate never drops `valid` after a beat has been presented mid-packet, because the gate only acts when `in_pkt` = 0.

## Structure
- **Shared package `stream_pkg`:** the `ctrl_state_t` enum (RUN, DRAIN, SWITCH) and a `dsp_mode_t` struct packing {`fir`, `dft`}, for reuse by the CSR glue.
- **Sub-module `stream_pkt_tracker`:** inputs `valid`, `ready`, `sop`, `eop`; outputs `in_pkt` and `eop_fire`. It is instantiated three times: upstream, downstream, and DSP egress (the DSP-egress instance feeds `pending`).

## Test plan
- **Bypass after reset:** 4-beat packet 0x1..0x4 on sink → identical beats on source in the same cycles; `dsp_sink_valid` = 0 throughout.
- **Enable FIR mid-packet:** assert `req_fir_en` at beat 3 of an 8-beat packet → beats 3..8 stay on bypass; `sink_ready` = 0 from the cycle after `eop`; `fir_en` = 1 two cycles after the boundary; the next packet appears on `dsp_sink_*`.
- **Disable with 2 packets inside the DSP:** `sink_ready` stays 0 until the DSP emits both `eop`s and `pending` = 0 → bypass restored at SWITCH+1.
- **Request reverts during DRAIN:** toggle `req_dft_en` 1→0 within 1 cycle → FSM returns to RUN, `dft_en` never changes, no SWITCH cycle.
- **Counter saturation with `CNT_W` = 2:** `dsp_source_ready` held 0, three 1-beat packets accepted → the fourth `sop` is stalled (`sink_ready` = 0) until one packet is emitted.
- **Reset mid-packet:** `rst_n` low for 1 cycle during beat 2 in DSP mode → next cycle in bypass, `pending` = 0, `fir_en` = 0, `switch_pending` = 0.
